// File: rtl/fpga_host_nbf_deserializer_pkg.sv
// ---------------------------------------------------------------------------
// fpga_host_nbf_deserializer_pkg
//   Shared types for the host-side NBF deserializer:
//     - NBF field widths and the NBF packet struct (opcode in the low byte,
//       so it is the first byte received over the UART)
//     - NBF opcode enumeration
//     - deserializer FSM state enumeration
//     - nbf_bytes(): number of UART bytes per NBF packet
// ---------------------------------------------------------------------------
package fpga_host_nbf_deserializer_pkg;

  localparam int unsigned nbf_opcode_width_gp = 8;
  localparam int unsigned nbf_addr_width_gp   = 40;
  localparam int unsigned nbf_data_width_gp   = 64;

  typedef enum logic [7:0] {
    e_fpga_host_nbf_write_4 = 8'h02,
    e_fpga_host_nbf_write_8 = 8'h03,
    e_fpga_host_nbf_read_4  = 8'h12,
    e_fpga_host_nbf_read_8  = 8'h13,
    e_fpga_host_nbf_fence   = 8'hFE,
    e_fpga_host_nbf_finish  = 8'hFF
  } bp_fpga_host_nbf_opcode_e;

  // Opcode sits in the least significant byte and therefore arrives first.
  typedef struct packed {
    logic [nbf_data_width_gp-1:0] data;
    logic [nbf_addr_width_gp-1:0] addr;
    bp_fpga_host_nbf_opcode_e     opcode;
  } bp_fpga_host_nbf_s;

  // e_idle: no partial packet held; e_collect: 1..N-1 bytes held.
  typedef enum logic {
    e_idle    = 1'b0,
    e_collect = 1'b1
  } bp_fpga_host_deser_state_e;

  // Whole bytes per NBF packet for the given address/data widths.
  function automatic int unsigned nbf_bytes(input int unsigned addr_width,
                                            input int unsigned data_width);
    return (nbf_opcode_width_gp + addr_width + data_width) / 8;
  endfunction

endpackage

// File: rtl/fpga_host_nbf_deserializer_if.sv
// ---------------------------------------------------------------------------
// fpga_host_nbf_deserializer_if
//   Bundles the UART byte stream, the NBF valid/ready-and output and the
//   status/error bits of the deserializer.
//   Signals:
//     rx_v_i          byte strobe from the UART receiver
//     rx_i            received byte
//     rx_error_i      receiver framing/parity error strobe
//     nbf_o           assembled NBF packet
//     nbf_v_o         nbf_o valid
//     nbf_ready_and_i consumer accepts nbf_o
//     busy_o          partial packet in progress
//     err_overflow_o  sticky: completed packet dropped, output occupied
//     err_timeout_o   sticky: partial packet discarded on inter-byte timeout
//     err_framing_o   sticky: partial packet discarded on rx_error_i
//     clear_err_i     synchronous clear of the sticky error bits
//   Modports:
//     master - environment (UART receiver + NBF consumer + status reader)
//     slave  - the deserializer
// ---------------------------------------------------------------------------
interface fpga_host_nbf_deserializer_if #(
  parameter int unsigned nbf_width_p = 112
) ();

  logic                   rx_v_i;
  logic [7:0]             rx_i;
  logic                   rx_error_i;
  logic [nbf_width_p-1:0] nbf_o;
  logic                   nbf_v_o;
  logic                   nbf_ready_and_i;
  logic                   busy_o;
  logic                   err_overflow_o;
  logic                   err_timeout_o;
  logic                   err_framing_o;
  logic                   clear_err_i;

  modport master (
    output rx_v_i, rx_i, rx_error_i, nbf_ready_and_i, clear_err_i,
    input  nbf_o, nbf_v_o, busy_o, err_overflow_o, err_timeout_o, err_framing_o
  );

  modport slave (
    input  rx_v_i, rx_i, rx_error_i, nbf_ready_and_i, clear_err_i,
    output nbf_o, nbf_v_o, busy_o, err_overflow_o, err_timeout_o, err_framing_o
  );

endinterface

// File: rtl/fpga_host_nbf_deserializer_gap_timer.sv
// ---------------------------------------------------------------------------
// fpga_host_nbf_gap_timer
//   Inter-byte gap counter. Counts enabled clocks since the last clear and
//   reports o_fire in the cycle the count reaches timeout_clks_p-1 without
//   a clear. The owner leaves the counting state on fire, so the count never
//   needs to go past timeout_clks_p and cannot wrap.
//   Ports:
//     i_clk     clock
//     i_rst     asynchronous active-high reset
//     i_clear   zero the count (takes priority over counting and firing)
//     i_enable  count this clock
//     o_fire    timeout reached this cycle
// ---------------------------------------------------------------------------
module fpga_host_nbf_gap_timer #(
  parameter int unsigned timeout_clks_p = 17360
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_fire
);

  localparam int unsigned          width_lp = $clog2(timeout_clks_p + 1);
  localparam logic [width_lp-1:0]  limit_lp = width_lp'(timeout_clks_p - 1);

  logic [width_lp-1:0] r_timer;

  // Gap counter: clear wins, otherwise count while enabled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_timer <= '0;
    end else if (i_clear) begin
      r_timer <= '0;
    end else if (i_enable) begin
      r_timer <= r_timer + width_lp'(1);
    end else begin
      r_timer <= r_timer;
    end
  end

  assign o_fire = i_enable & ~i_clear & (r_timer == limit_lp);

endmodule

// File: rtl/fpga_host_nbf_deserializer.sv
// ---------------------------------------------------------------------------
// fpga_host_nbf_deserializer
//   Assembles the UART receiver's byte stream into complete NBF packets
//   (least significant byte first) and presents each packet on a
//   valid/ready-and output through a one-entry holding register.
//   The UART cannot be stalled, so a completed packet that finds the output
//   still occupied is dropped (sticky overflow). A partial packet is
//   discarded on an inter-byte timeout (sticky timeout) or on a receiver
//   error (sticky framing).
//   Ports:
//     clk_i    clock
//     reset_i  asynchronous active-high reset
//     bus      fpga_host_nbf_deserializer_if.slave (byte input, NBF output,
//              busy and sticky error status, error clear)
// ---------------------------------------------------------------------------
module fpga_host_nbf_deserializer
  import fpga_host_nbf_deserializer_pkg::*;
#(
  parameter int unsigned nbf_addr_width_p = nbf_addr_width_gp,
  parameter int unsigned nbf_data_width_p = nbf_data_width_gp,
  parameter int unsigned uart_data_bits_p = 8,
  parameter int unsigned timeout_clks_p   = 17360
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  fpga_host_nbf_deserializer_if.slave bus
);

  localparam int unsigned nbf_width_lp   = nbf_opcode_width_gp + nbf_addr_width_p + nbf_data_width_p;
  localparam int unsigned nbf_bytes_lp   = nbf_bytes(nbf_addr_width_p, nbf_data_width_p);
  localparam int unsigned count_width_lp = $clog2(nbf_bytes_lp);
  localparam logic [count_width_lp-1:0] last_byte_lp = count_width_lp'(nbf_bytes_lp - 1);

  if ((uart_data_bits_p != 32'd8) || ((nbf_width_lp % 32'd8) != 32'd0)) begin : g_cfg_check
    $error("fpga_host_nbf_deserializer: UART must deliver 8-bit bytes and the NBF packet must be a whole number of bytes");
  end

  bp_fpga_host_deser_state_e  r_state;
  bp_fpga_host_deser_state_e  w_state_next;
  logic [count_width_lp-1:0]  r_count;
  logic [count_width_lp-1:0]  w_count_next;
  logic [nbf_width_lp-1:0]    r_asm;
  logic [nbf_width_lp-1:0]    w_asm_next;

  logic [nbf_width_lp-1:0]    r_nbf;
  logic                       r_nbf_v;
  logic                       r_err_overflow;
  logic                       r_err_timeout;
  logic                       r_err_framing;

  logic                       w_fire;
  logic                       w_byte_take;
  logic                       w_complete;
  logic                       w_handshake;
  logic                       w_load;
  logic                       w_overflow_set;
  logic                       w_timeout_set;
  logic [nbf_width_lp-1:0]    w_pkt;

  // A receiver error suppresses the byte presented with it.
  assign w_byte_take    = bus.rx_v_i & ~bus.rx_error_i;
  assign w_complete     = (r_state == e_collect) & w_byte_take & (r_count == last_byte_lp);
  assign w_handshake    = r_nbf_v & bus.nbf_ready_and_i;
  // The holding register frees up in the same cycle it hands off, so a packet
  // completing on a handshake cycle still loads.
  assign w_load         = w_complete & (~r_nbf_v | bus.nbf_ready_and_i);
  assign w_overflow_set = w_complete & r_nbf_v & ~bus.nbf_ready_and_i;
  // The framing discard takes precedence when both happen in one cycle.
  assign w_timeout_set  = w_fire & ~bus.rx_error_i;
  // Final byte goes straight into the output; the assembly register only holds 0..N-2.
  assign w_pkt          = {bus.rx_i, r_asm[nbf_width_lp-9:0]};

  fpga_host_nbf_gap_timer #(
    .timeout_clks_p (timeout_clks_p)
  ) u_gap_timer (
    .i_clk    (clk_i),
    .i_rst    (reset_i),
    .i_clear  (bus.rx_v_i | (r_state == e_idle)),
    .i_enable (r_state == e_collect),
    .o_fire   (w_fire)
  );

  // Assembly state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= e_idle;
      r_count <= '0;
      r_asm   <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_asm   <= w_asm_next;
    end
  end

  // Assembly next state: receiver error discards, a byte is stored, or the gap timer discards.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_asm_next   = r_asm;
    case (r_state)
      e_idle: begin
        if (w_byte_take) begin
          w_asm_next[7:0] = bus.rx_i;
          w_count_next    = count_width_lp'(1);
          w_state_next    = e_collect;
        end else begin
          w_state_next = e_idle;
        end
      end
      e_collect: begin
        if (bus.rx_error_i) begin
          w_asm_next   = '0;
          w_count_next = '0;
          w_state_next = e_idle;
        end else if (bus.rx_v_i) begin
          if (r_count == last_byte_lp) begin
            w_asm_next   = '0;
            w_count_next = '0;
            w_state_next = e_idle;
          end else begin
            w_asm_next[{r_count, 3'b000} +: 8] = bus.rx_i;
            w_count_next = r_count + count_width_lp'(1);
            w_state_next = e_collect;
          end
        end else if (w_fire) begin
          w_asm_next   = '0;
          w_count_next = '0;
          w_state_next = e_idle;
        end else begin
          w_state_next = e_collect;
        end
      end
      default: begin
        w_asm_next   = '0;
        w_count_next = '0;
        w_state_next = e_idle;
      end
    endcase
  end

  // One-entry output holding register with valid/ready-and handshake.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_nbf   <= '0;
      r_nbf_v <= 1'b0;
    end else if (w_load) begin
      r_nbf   <= w_pkt;
      r_nbf_v <= 1'b1;
    end else if (w_handshake) begin
      r_nbf   <= r_nbf;
      r_nbf_v <= 1'b0;
    end else begin
      r_nbf   <= r_nbf;
      r_nbf_v <= r_nbf_v;
    end
  end

  // Sticky overflow flag; a new event beats a simultaneous clear.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_err_overflow <= 1'b0;
    end else if (w_overflow_set) begin
      r_err_overflow <= 1'b1;
    end else if (bus.clear_err_i) begin
      r_err_overflow <= 1'b0;
    end else begin
      r_err_overflow <= r_err_overflow;
    end
  end

  // Sticky timeout flag; a new event beats a simultaneous clear.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_err_timeout <= 1'b0;
    end else if (w_timeout_set) begin
      r_err_timeout <= 1'b1;
    end else if (bus.clear_err_i) begin
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= r_err_timeout;
    end
  end

  // Sticky framing flag; set on any receiver error, including with no partial packet.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_err_framing <= 1'b0;
    end else if (bus.rx_error_i) begin
      r_err_framing <= 1'b1;
    end else if (bus.clear_err_i) begin
      r_err_framing <= 1'b0;
    end else begin
      r_err_framing <= r_err_framing;
    end
  end

  assign bus.nbf_o          = r_nbf;
  assign bus.nbf_v_o        = r_nbf_v;
  assign bus.busy_o         = (r_state == e_collect);
  assign bus.err_overflow_o = r_err_overflow;
  assign bus.err_timeout_o  = r_err_timeout;
  assign bus.err_framing_o  = r_err_framing;

endmodule

// File: tb/tb_fpga_host_nbf_deserializer.sv
// ---------------------------------------------------------------------------
// tb_fpga_host_nbf_deserializer
//   Drives bytes straight onto rx_v_i/rx_i and compares the deserializer
//   against a queue-based packet model on every falling edge, plus directed
//   scenarios with literal expectations.
// ---------------------------------------------------------------------------
module tb_fpga_host_nbf_deserializer;
  import fpga_host_nbf_deserializer_pkg::*;

  localparam int TO = 64;
  localparam int NB = 14;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   xfers  = 0;
  logic [111:0] dut_log[$];

  fpga_host_nbf_deserializer_if #(.nbf_width_p(112)) bus ();

  fpga_host_nbf_deserializer #(
    .nbf_addr_width_p (40),
    .nbf_data_width_p (64),
    .uart_data_bits_p (8),
    .timeout_clks_p   (TO)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [111:0] act, input logic [111:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Bytes of the partial packet in arrival order, clocks since the last byte,
  // the single output slot and the three sticky flags.
  logic [7:0]   m_q[$];
  int           m_gap  = 0;
  logic         m_v    = 1'b0;
  logic [111:0] m_data = '0;
  logic         m_ovf  = 1'b0;
  logic         m_to   = 1'b0;
  logic         m_fr   = 1'b0;
  logic         m_done;
  logic         m_hs;
  logic [111:0] m_pkt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_gap  = 0;
      m_v    = 1'b0;
      m_data = '0;
      m_ovf  = 1'b0;
      m_to   = 1'b0;
      m_fr   = 1'b0;
    end else begin
      m_hs   = m_v && bus.nbf_ready_and_i;
      m_done = 1'b0;
      m_pkt  = '0;
      if (bus.clear_err_i) begin
        m_ovf = 1'b0;
        m_to  = 1'b0;
        m_fr  = 1'b0;
      end
      if (bus.rx_error_i) begin
        m_q.delete();
        m_fr = 1'b1;
      end else if (bus.rx_v_i) begin
        m_q.push_back(bus.rx_i);
        m_gap = 0;
        if (m_q.size() == NB) begin
          for (int i = 0; i < NB; i++) m_pkt[8*i +: 8] = m_q[i];
          m_q.delete();
          m_done = 1'b1;
        end
      end else if (m_q.size() != 0) begin
        m_gap++;
        if (m_gap == TO) begin
          m_q.delete();
          m_to = 1'b1;
        end
      end
      if (m_done && (!m_v || m_hs)) begin
        m_data = m_pkt;
        m_v    = 1'b1;
      end else begin
        if (m_done) m_ovf = 1'b1;
        if (m_hs)   m_v   = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model; also logs DUT transfers.
  always @(negedge clk) begin
    chk1("cyc_nbf_v", bus.nbf_v_o, m_v);
    chkw("cyc_nbf", bus.nbf_o, m_data);
    chk1("cyc_busy", bus.busy_o, m_q.size() != 0);
    chk1("cyc_err_overflow", bus.err_overflow_o, m_ovf);
    chk1("cyc_err_timeout", bus.err_timeout_o, m_to);
    chk1("cyc_err_framing", bus.err_framing_o, m_fr);
    if (bus.nbf_v_o && bus.nbf_ready_and_i) begin
      xfers++;
      dut_log.push_back(bus.nbf_o);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_bytes(input logic [111:0] p, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      bus.rx_v_i = 1'b1;
      bus.rx_i   = p[8*i +: 8];
      tick();
      bus.rx_v_i = 1'b0;
    end
  endtask

  task automatic pulse_clear();
    bus.clear_err_i = 1'b1;
    tick();
    bus.clear_err_i = 1'b0;
  endtask

  function automatic logic [111:0] rand_pkt(input logic [7:0] op);
    return {32'($urandom), 32'($urandom), 8'($urandom), 32'($urandom), op};
  endfunction

  logic [111:0] pa, pb, pr, p1, p2;
  int x0, l0;

  initial begin
    bus.rx_v_i = 1'b0; bus.rx_i = 8'h00; bus.rx_error_i = 1'b0;
    bus.nbf_ready_and_i = 1'b1; bus.clear_err_i = 1'b0;
    #1 rst = 1'b1;
    repeat (3) tick();
    chk1("reset_nbf_v", bus.nbf_v_o, 1'b0);
    chkw("reset_nbf", bus.nbf_o, 112'h0);
    chk1("reset_busy", bus.busy_o, 1'b0);
    rst = 1'b0;
    tick();

    // 1: fence packet, ready high
    send_bytes({104'h0, 8'hFE}, 0, 12);
    chk1("t1_busy_mid", bus.busy_o, 1'b1);
    send_bytes({104'h0, 8'hFE}, 13, 13);
    chk1("t1_nbf_v", bus.nbf_v_o, 1'b1);
    chkw("t1_nbf", bus.nbf_o, {104'h0, 8'hFE});
    chkw("t1_model", m_data, {104'h0, 8'hFE});
    chk1("t1_busy_done", bus.busy_o, 1'b0);
    tick();
    chk1("t1_v_cleared", bus.nbf_v_o, 1'b0);

    // 2: overflow while ready low
    bus.nbf_ready_and_i = 1'b0;
    pa = {64'h0, 40'h12_3456_789A, 8'h03};
    pb = {64'h1, 40'h12_3456_789A, 8'h03};
    send_bytes(pa, 0, NB-1);
    send_bytes(pb, 0, NB-1);
    chkw("t2_nbf_held", bus.nbf_o, {64'h0, 40'h12_3456_789A, 8'h03});
    chk1("t2_overflow", bus.err_overflow_o, 1'b1);
    chk1("t2_model_ovf", m_ovf, 1'b1);
    x0 = xfers;
    bus.nbf_ready_and_i = 1'b1;
    repeat (4) tick();
    chki("t2_one_xfer", xfers - x0, 1);

    // 3: gap of exactly timeout-1 idle clocks survives, 70 idle clocks discard
    pulse_clear();
    send_bytes({104'h0, 8'h11}, 0, 0);
    repeat (TO-1) tick();
    send_bytes({104'h0, 8'h22}, 0, 0);
    chk1("t3_boundary_busy", bus.busy_o, 1'b1);
    chk1("t3_boundary_no_to", bus.err_timeout_o, 1'b0);
    send_bytes(112'h33_3333_33, 0, 2);
    repeat (70) tick();
    chk1("t3_timeout", bus.err_timeout_o, 1'b1);
    chk1("t3_idle", bus.busy_o, 1'b0);
    bus.nbf_ready_and_i = 1'b0;
    pr = {64'hDEAD_BEEF_0BAD_F00D, 40'h00_8000_1000, 8'h13};
    send_bytes(pr, 0, NB-1);
    chkw("t3_read8", bus.nbf_o, {64'hDEAD_BEEF_0BAD_F00D, 40'h00_8000_1000, 8'h13});
    x0 = xfers;
    bus.nbf_ready_and_i = 1'b1;
    repeat (3) tick();
    chki("t3_one_xfer", xfers - x0, 1);

    // 4: framing error after byte 7, then finish
    pulse_clear();
    bus.nbf_ready_and_i = 1'b0;
    send_bytes(rand_pkt(8'h03), 0, 6);
    bus.rx_error_i = 1'b1;
    bus.rx_v_i = 1'b1; bus.rx_i = 8'hA5;
    tick();
    bus.rx_error_i = 1'b0; bus.rx_v_i = 1'b0;
    chk1("t4_framing", bus.err_framing_o, 1'b1);
    chk1("t4_discarded", bus.busy_o, 1'b0);
    send_bytes({104'h0, 8'hFF}, 0, NB-1);
    chkw("t4_finish", bus.nbf_o, {104'h0, 8'hFF});
    chk1("t4_framing_kept", bus.err_framing_o, 1'b1);
    pulse_clear();
    chk1("t4_clr_ovf", bus.err_overflow_o, 1'b0);
    chk1("t4_clr_to", bus.err_timeout_o, 1'b0);
    chk1("t4_clr_fr", bus.err_framing_o, 1'b0);
    bus.nbf_ready_and_i = 1'b1;
    repeat (2) tick();

    // 5: completion of packet 2 coincides with handshake of packet 1
    bus.nbf_ready_and_i = 1'b0;
    p1 = rand_pkt(8'h02);
    p2 = rand_pkt(8'h12);
    l0 = dut_log.size();
    send_bytes(p1, 0, NB-1);
    send_bytes(p2, 0, NB-2);
    bus.nbf_ready_and_i = 1'b1;
    send_bytes(p2, NB-1, NB-1);
    chk1("t5_no_overflow", bus.err_overflow_o, 1'b0);
    chkw("t5_p2_loaded", bus.nbf_o, p2);
    repeat (2) tick();
    chki("t5_xfers", dut_log.size() - l0, 2);
    if (dut_log.size() - l0 >= 2) begin
      chkw("t5_first", dut_log[l0], p1);
      chkw("t5_second", dut_log[l0+1], p2);
    end

    // random traffic: bytes, gaps near the timeout, errors, clears, back-pressure
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(299) == 0) begin
        bus.rx_v_i = 1'b0; bus.rx_error_i = 1'b0; bus.clear_err_i = 1'b0;
        repeat ($urandom_range(TO+4, TO-4)) tick();
      end else begin
        bus.rx_v_i          = ($urandom_range(2) == 0);
        bus.rx_i            = 8'($urandom);
        bus.rx_error_i      = ($urandom_range(199) == 0);
        bus.clear_err_i     = ($urandom_range(149) == 0);
        bus.nbf_ready_and_i = ($urandom_range(9) < 7);
        tick();
      end
    end
    bus.rx_v_i = 1'b0; bus.rx_error_i = 1'b0; bus.clear_err_i = 1'b0;
    bus.nbf_ready_and_i = 1'b1;
    repeat (TO+4) tick();

    // 6: asynchronous reset mid-cycle while byte 10 is presented
    bus.nbf_ready_and_i = 1'b0;
    send_bytes(rand_pkt(8'h13), 0, NB-1);
    bus.rx_error_i = 1'b1;
    tick();
    bus.rx_error_i = 1'b0;
    p1 = rand_pkt(8'h03);
    send_bytes(p1, 0, 9);
    bus.rx_v_i = 1'b1; bus.rx_i = p1[87:80];
    #1 rst = 1'b1;
    #1;
    chk1("t6_nbf_v", bus.nbf_v_o, 1'b0);
    chkw("t6_nbf", bus.nbf_o, 112'h0);
    chk1("t6_busy", bus.busy_o, 1'b0);
    chk1("t6_ovf", bus.err_overflow_o, 1'b0);
    chk1("t6_to", bus.err_timeout_o, 1'b0);
    chk1("t6_fr", bus.err_framing_o, 1'b0);
    bus.rx_v_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    p2 = rand_pkt(8'hFE);
    send_bytes(p2, 0, NB-1);
    chk1("t6_after_v", bus.nbf_v_o, 1'b1);
    chkw("t6_after_pkt", bus.nbf_o, p2);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
